serial_chunk_adder: RTL and testbench

SERIAL_CHUNK_ADDER -- requirements
Module: serial_chunk_adder

---
 rtl/serial_chunk_adder.sv | 151 +++++++++++++++
 tb/tb_serial_chunk_adder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_chunk_adder.sv
// serial_chunk_adder
//   Adds two WIDTH-bit operands CHUNK bits per clock, LSB slice first, with
//   the slice carry rippled through a register into the next slice. A
//   three-state FSM (IDLE / RUN / DONE) sequences the operation: start is
//   accepted in IDLE or DONE, RUN lasts exactly N = WIDTH/CHUNK cycles, and
//   DONE is a single cycle in which done pulses. sum and cout are loaded on
//   the edge that leaves RUN and are held until the next completion or reset.
//
//   Optional feature macro: SERIAL_ADD_SUB_EN
//     When defined, adds input sub (sampled with start; 1 = a - b computed as
//     a + ~b + 1, cin ignored) and output ovf (signed two's-complement
//     overflow, loaded together with sum). When undefined the block is an
//     adder only and those ports do not exist.
//
// Parameters
//   WIDTH : operand / sum width in bits
//   CHUNK : bits added per RUN cycle (WIDTH must be a multiple of CHUNK)
//
// Ports
//   clk   in   single clock, rising-edge
//   rst   in   synchronous active-high reset
//   start in   begin an addition (accepted only in IDLE or DONE)
//   a, b  in   WIDTH-bit operands, sampled when start is accepted
//   cin   in   carry-in, sampled when start is accepted
//   sub   in   (SERIAL_ADD_SUB_EN only) subtract select, sampled with start
//   ovf   out  (SERIAL_ADD_SUB_EN only) registered signed overflow flag
//   busy  out  high during the N RUN cycles
//   done  out  one-cycle completion pulse (DONE state)
//   sum   out  registered WIDTH-bit result
//   cout  out  registered carry-out of the MSB slice
module serial_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
  output logic             ovf,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, nstate;
  logic [WIDTH-1:0] a_r, b_r;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc, acc_next;
  logic [CHUNK:0]   slice_sum;
  logic             accept;
  logic             last;

`ifdef SERIAL_ADD_SUB_EN
  // Overflow when both addends share a sign that the result does not.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction
`endif

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (cnt == LAST);

  // Operand registers shift right each RUN cycle, so the current slice is
  // always in the low CHUNK bits.
  assign slice_sum = {1'b0, a_r[CHUNK-1:0]} + {1'b0, b_r[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, carry};

  always_comb begin
    acc_next = acc;
    acc_next[int'(cnt)*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  // Next-state logic
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    nstate = start ? RUN : IDLE;
      RUN:     nstate = last ? DONE : RUN;
      DONE:    nstate = start ? RUN : IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Datapath: operand capture, per-slice add, result load on RUN exit
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      ovf   <= 1'b0;
`endif
    end else if (accept) begin
      a_r   <= a;
`ifdef SERIAL_ADD_SUB_EN
      b_r   <= sub ? ~b : b;
      carry <= sub ? 1'b1 : cin;
`else
      b_r   <= b;
      carry <= cin;
`endif
      cnt   <= '0;
      acc   <= '0;
    end else if (state == RUN) begin
      a_r   <= a_r >> CHUNK;
      b_r   <= b_r >> CHUNK;
      carry <= slice_sum[CHUNK];
      cnt   <= cnt + CW'(1);
      acc   <= acc_next;
      if (last) begin
        sum  <= acc_next;
        cout <= slice_sum[CHUNK];
`ifdef SERIAL_ADD_SUB_EN
        // On the last slice the top bits of a_r/b_r are the operand MSBs.
        ovf  <= signed_ovf(a_r[CHUNK-1], b_r[CHUNK-1], slice_sum[CHUNK-1]);
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_chunk_adder.sv
module tb_serial_chunk_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a, b;
  logic        cin;
  logic        busy, done;
  logic [15:0] sum;
  logic        cout;

  logic        start8;
  logic [7:0]  a8, b8;
  logic        cin8;
  logic        busy8, done8;
  logic [7:0]  sum8;
  logic        cout8;

`ifdef SERIAL_ADD_SUB_EN
  logic        sub, ovf, sub8, ovf8;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub), .ovf(ovf),
`endif
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub8), .ovf(ovf8),
`endif
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge with the given operands; returns just after
  // the accepting edge.
  task automatic launch(input logic [15:0] va, input logic [15:0] vb,
                        input logic vc);
    a = va; b = vb; cin = vc; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Count edges until done is seen, bounded; n_out starts at n_in.
  task automatic wait_done(input int n_in, output int n_out);
    int n;
    n = n_in;
    while (done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    n_out = n;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (sum !== 16'h0000) begin failures++; $display("FAIL reset_sum got=%h exp=0000", sum); end
    checks++; if (cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", cout); end
    checks++; if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h00) begin
      failures++; $display("FAIL reset_w8 got busy=%b done=%b sum=%h exp 0/0/00", busy8, done8, sum8);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_carry_chain();
    launch(16'hFFFF, 16'h0001, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin
        failures++; $display("FAIL chain_run%0d got busy=%b done=%b exp busy=1 done=0", i, busy, done);
      end
      tick();
    end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL chain_done got done=%b busy=%b exp 1/0", done, busy); end
    checks++; if (sum !== 16'h0000) begin failures++; $display("FAIL chain_sum got=%h exp=0000", sum); end
    checks++; if (cout !== 1'b1) begin failures++; $display("FAIL chain_cout got=%b exp=1", cout); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL chain_idle got done=%b busy=%b exp 0/0", done, busy); end
    checks++; if (sum !== 16'h0000 || cout !== 1'b1) begin failures++; $display("FAIL chain_hold got sum=%h cout=%b exp 0000/1", sum, cout); end
  endtask

  task automatic test_start_held();
    a = 16'h1234; b = 16'h4321; cin = 1'b1; start = 1'b1;
    tick();
    // Operands changed while start stays high must be ignored.
    a = 16'hDEAD; b = 16'hBEEF; cin = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin
        failures++; $display("FAIL held_run%0d got busy=%b done=%b exp 1/0", i, busy, done);
      end
      tick();
    end
    start = 1'b0;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL held_done got=%b exp=1", done); end
    checks++; if (sum !== 16'h5556) begin failures++; $display("FAIL held_sum got=%h exp=5556", sum); end
    checks++; if (cout !== 1'b0) begin failures++; $display("FAIL held_cout got=%b exp=0", cout); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL held_after got done=%b busy=%b exp 0/0", done, busy); end
  endtask

  task automatic test_back_to_back();
    int n;
    launch(16'h0010, 16'h0020, 1'b0);
    wait_done(0, n);
    checks++; if (n !== 4) begin failures++; $display("FAIL b2b_first_lat got=%0d exp=4", n); end
    checks++; if (sum !== 16'h0030) begin failures++; $display("FAIL b2b_first_sum got=%h exp=0030", sum); end
    launch(16'h0001, 16'h0001, 1'b0);
    wait_done(1, n);
    checks++; if (n !== 5) begin failures++; $display("FAIL b2b_gap got=%0d exp=5", n); end
    checks++; if (sum !== 16'h0002 || cout !== 1'b0) begin failures++; $display("FAIL b2b_sum got=%h/%b exp=0002/0", sum, cout); end
    tick();
  endtask

  task automatic test_patterns();
    int n;
    launch(16'hA5A5, 16'h5A5A, 1'b1);
    wait_done(0, n);
    checks++; if (sum !== 16'h0000 || cout !== 1'b1) begin failures++; $display("FAIL pat_a5_sum got=%h/%b exp=0000/1", sum, cout); end
    tick();
    launch(16'h8000, 16'h8000, 1'b1);
    wait_done(0, n);
    checks++; if (sum !== 16'h0001 || cout !== 1'b1) begin failures++; $display("FAIL pat_80_sum got=%h/%b exp=0001/1", sum, cout); end
    tick();
    launch(16'h0F0F, 16'h00F1, 1'b0);
    wait_done(0, n);
    checks++; if (sum !== 16'h1000 || cout !== 1'b0) begin failures++; $display("FAIL pat_ripple_sum got=%h/%b exp=1000/0", sum, cout); end
    tick();
  endtask

  task automatic test_reset_abort();
    bit seen;
    launch(16'h1111, 16'h2222, 1'b0);
    tick();
    rst = 1'b1; start = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL abort_ctrl got busy=%b done=%b exp 0/0", busy, done); end
    checks++; if (sum !== 16'h0000 || cout !== 1'b0) begin failures++; $display("FAIL abort_data got=%h/%b exp=0000/0", sum, cout); end
    rst = 1'b0; start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_done got activity=%b exp=0", seen); end
  endtask

  task automatic test_single_chunk();
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    checks++; if (busy8 !== 1'b1 || done8 !== 1'b0) begin failures++; $display("FAIL w8_run got busy=%b done=%b exp 1/0", busy8, done8); end
    tick();
    checks++; if (busy8 !== 1'b0 || done8 !== 1'b1) begin failures++; $display("FAIL w8_done got busy=%b done=%b exp 0/1", busy8, done8); end
    checks++; if (sum8 !== 8'h00 || cout8 !== 1'b1) begin failures++; $display("FAIL w8_sum got=%h/%b exp=00/1", sum8, cout8); end
    tick();
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub();
    int n;
    sub = 1'b1;
    launch(16'h0005, 16'h0007, 1'b0);
    sub = 1'b0;
    wait_done(0, n);
    checks++; if (sum !== 16'hFFFE || cout !== 1'b0 || ovf !== 1'b0) begin
      failures++; $display("FAIL sub_5m7 got=%h/%b/%b exp=FFFE/0/0", sum, cout, ovf);
    end
    tick();
    launch(16'h7FFF, 16'h0001, 1'b0);
    wait_done(0, n);
    checks++; if (sum !== 16'h8000 || cout !== 1'b0 || ovf !== 1'b1) begin
      failures++; $display("FAIL add_ovf got=%h/%b/%b exp=8000/0/1", sum, cout, ovf);
    end
    tick();
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0; sub8 = 1'b0;
`endif
    test_reset();
    test_carry_chain();
    test_start_held();
    test_back_to_back();
    test_patterns();
    test_reset_abort();
    test_single_chunk();
`ifdef SERIAL_ADD_SUB_EN
    test_sub();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
